// File: rtl/seq_det_arbiter.sv
// Two-channel round-robin arbiter feeding a shared serial 111/101 pattern detector.
// One frame is processed at a time; per-frame match count saturates at 2^CNT_W-1.
module seq_det_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             req1,
    input  logic             din0,
    input  logic             din1,
    input  logic             last0,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             det_111,
    output logic             det_101,
    output logic             done,
    output logic             done_id,
    output logic [CNT_W-1:0] match_cnt
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        REPORT = 2'd2
    } state_t;

    state_t     state;
    logic       ptr;
    logic       ch;
    logic [1:0] hist;
    logic [1:0] nbits;

    logic pick;
    logic cur_req;
    logic cur_din;
    logic cur_last;
    logic hit111;
    logic hit101;

    // With both requests pending the pointer channel wins; otherwise the lone requester.
    assign pick     = (req0 && req1) ? ptr : req1;
    assign cur_req  = ch ? req1  : req0;
    assign cur_din  = ch ? din1  : din0;
    assign cur_last = ch ? last1 : last0;
    assign hit111   = (nbits == 2'd2) && (hist == 2'b11) && cur_din;
    assign hit101   = (nbits == 2'd2) && (hist == 2'b10) && cur_din;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= 1'b0;
            ch        <= 1'b0;
            hist      <= '0;
            nbits     <= '0;
            gnt0      <= 1'b0;
            gnt1      <= 1'b0;
            det_111   <= 1'b0;
            det_101   <= 1'b0;
            done      <= 1'b0;
            done_id   <= 1'b0;
            match_cnt <= '0;
        end else begin
            det_111 <= 1'b0;
            det_101 <= 1'b0;
            done    <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        ch        <= pick;
                        gnt0      <= ~pick;
                        gnt1      <= pick;
                        match_cnt <= '0;
                        hist      <= '0;
                        nbits     <= '0;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    if (!cur_req) begin
                        gnt0  <= 1'b0;
                        gnt1  <= 1'b0;
                        ptr   <= ~ptr;
                        state <= IDLE;
                    end else begin
                        det_111 <= hit111;
                        det_101 <= hit101;
                        if ((hit111 || hit101) && !(&match_cnt))
                            match_cnt <= match_cnt + CNT_W'(1);
                        hist <= {hist[0], cur_din};
                        if (nbits != 2'd2)
                            nbits <= nbits + 2'd1;
                        if (cur_last) begin
                            gnt0    <= 1'b0;
                            gnt1    <= 1'b0;
                            done    <= 1'b1;
                            done_id <= ch;
                            ptr     <= ~ptr;
                            state   <= REPORT;
                        end
                    end
                end
                REPORT: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_seq_det_arbiter.sv
// Scenario bench for seq_det_arbiter: per-bit expectations from a string-based
// pattern model are queued as bits are driven and popped after each consuming edge.
module tb_seq_det_arbiter;

    logic       clk = 1'b0;
    logic       rst, req0, req1, din0, din1, last0, last1;
    logic       gnt0, gnt1, det_111, det_101, done, done_id;
    logic [7:0] match_cnt;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       d111;
        logic       d101;
        logic       dn;
        logic       id;
        logic       gnt;
        logic [7:0] cnt;
    } exp_t;

    exp_t q[$];

    seq_det_arbiter #(.CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .din0(din0), .din1(din1),
        .last0(last0), .last1(last1),
        .gnt0(gnt0), .gnt1(gnt1),
        .det_111(det_111), .det_101(det_101),
        .done(done), .done_id(done_id),
        .match_cnt(match_cnt)
    );

    always #5 clk = ~clk;

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        din0 = 1'b0; din1 = 1'b0; last0 = 1'b0; last1 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic wait_grant(input bit ch, input int exp_cycles);
        int   k;
        logic got;
        k = 0;
        got = 1'b0;
        while (got !== 1'b1 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
            got = ch ? gnt1 : gnt0;
        end
        checks++;
        if (got !== 1'b1 || k != exp_cycles || (ch ? gnt0 : gnt1) !== 1'b0) begin
            errors++;
            $display("FAIL grant_ch%0d: granted=%b after %0d cycles other_gnt=%b, expected grant after %0d cycles other_gnt=0",
                     ch, got, k, ch ? gnt0 : gnt1, exp_cycles);
        end
    endtask

    // Drives frame s on channel ch; at bit index cut either drops req (abort) or asserts rst.
    task automatic feed_frame(input bit ch, input string s, input int cut, input bit use_rst);
        exp_t       e, g;
        logic [7:0] cnt;
        int         len;
        bit         b, lst, h111, h101;
        cnt = 8'd0;
        len = s.len();
        q.delete();
        for (int i = 0; i < len; i++) begin
            if (i == cut) begin
                if (use_rst) rst = 1'b1;
                else if (ch) req1 = 1'b0;
                else req0 = 1'b0;
                last0 = 1'b0; last1 = 1'b0;
                @(posedge clk);
                #1;
                checks++;
                if ({gnt0, gnt1, det_111, det_101, done} !== 5'b0 ||
                    match_cnt !== (use_rst ? 8'd0 : cnt) || (use_rst && done_id !== 1'b0)) begin
                    errors++;
                    $display("FAIL cut_%s_bit%0d: gnt=%b%b det111=%b det101=%b done=%b id=%b cnt=%0d, expected gnt/det/done 0 cnt=%0d",
                             use_rst ? "reset" : "abort", i + 1, gnt0, gnt1, det_111, det_101, done, done_id,
                             match_cnt, use_rst ? 0 : cnt);
                end
                return;
            end
            b = (s[i] == "1");
            lst = (i == len - 1);
            h111 = 1'b0;
            h101 = 1'b0;
            if (i >= 2) begin
                h111 = (s[i-2] == "1") && (s[i-1] == "1") && b;
                h101 = (s[i-2] == "1") && (s[i-1] == "0") && b;
            end
            if ((h111 || h101) && cnt != 8'hff) cnt = cnt + 8'd1;
            e.d111 = h111; e.d101 = h101; e.dn = lst; e.id = ch; e.gnt = !lst; e.cnt = cnt;
            q.push_back(e);
            if (ch) begin
                din1 = b; last1 = lst; din0 = 1'($urandom); last0 = 1'($urandom);
            end else begin
                din0 = b; last0 = lst; din1 = 1'($urandom); last1 = 1'($urandom);
            end
            @(posedge clk);
            #1;
            g = q.pop_front();
            checks++;
            if (det_111 !== g.d111 || det_101 !== g.d101 || done !== g.dn || match_cnt !== g.cnt ||
                (ch ? gnt1 : gnt0) !== g.gnt || (ch ? gnt0 : gnt1) !== 1'b0 || (g.dn && done_id !== g.id)) begin
                errors++;
                $display("FAIL bit%0d_ch%0d: det111=%b det101=%b done=%b id=%b gnt=%b%b cnt=%0d, expected det111=%b det101=%b done=%b id=%b gnt_ch=%b cnt=%0d",
                         i + 1, ch, det_111, det_101, done, done_id, gnt0, gnt1, match_cnt,
                         g.d111, g.d101, g.dn, g.id, g.gnt, g.cnt);
            end
        end
        last0 = 1'b0; last1 = 1'b0;
        if (ch) req1 = 1'b0;
        else req0 = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({gnt0, gnt1, det_111, det_101, done, done_id, match_cnt} !== 14'b0) begin
            errors++;
            $display("FAIL reset_state: gnt=%b%b det=%b%b done=%b id=%b cnt=%0d, expected all 0",
                     gnt0, gnt1, det_111, det_101, done, done_id, match_cnt);
        end
    endtask

    task automatic test_frame20();
        req0 = 1'b1;
        wait_grant(1'b0, 1);
        feed_frame(1'b0, "11100101001110010111", -1, 1'b0);
        idle_cycles(3);
    endtask

    task automatic test_round_robin();
        apply_reset();
        req0 = 1'b1; req1 = 1'b1;
        wait_grant(1'b0, 1);
        feed_frame(1'b0, "1011", -1, 1'b0);
        wait_grant(1'b1, 2);
        feed_frame(1'b1, "0111", -1, 1'b0);
        req0 = 1'b1; req1 = 1'b1;
        wait_grant(1'b0, 2);
        feed_frame(1'b0, "1", -1, 1'b0);
        req1 = 1'b0;
        idle_cycles(3);
    endtask

    task automatic test_saturate();
        string ones;
        ones = "";
        for (int i = 0; i < 300; i++) ones = {ones, "1"};
        req1 = 1'b1;
        wait_grant(1'b1, 1);
        feed_frame(1'b1, ones, -1, 1'b0);
        idle_cycles(3);
    endtask

    task automatic test_abort();
        req0 = 1'b1;
        wait_grant(1'b0, 1);
        feed_frame(1'b0, "111", 2, 1'b0);
        req0 = 1'b1;
        wait_grant(1'b0, 1);
        feed_frame(1'b0, "111", -1, 1'b0);
        idle_cycles(3);
    endtask

    task automatic test_101_last();
        req0 = 1'b1;
        wait_grant(1'b0, 1);
        feed_frame(1'b0, "10101", -1, 1'b0);
        idle_cycles(3);
    endtask

    task automatic test_reset_mid();
        req0 = 1'b1; req1 = 1'b1;
        wait_grant(1'b1, 1);
        feed_frame(1'b1, "1110111", 4, 1'b1);
        req0 = 1'b1; req1 = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({gnt0, gnt1} !== 2'b00) begin
            errors++;
            $display("FAIL grant_during_rst: gnt=%b%b, expected 00", gnt0, gnt1);
        end
        rst = 1'b0;
        wait_grant(1'b0, 1);
        feed_frame(1'b0, "101", -1, 1'b0);
        req1 = 1'b0;
        idle_cycles(3);
    endtask

    initial begin
        test_reset();
        test_frame20();
        test_round_robin();
        test_saturate();
        test_abort();
        test_101_last();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seq_det_arbiter.md
SEQ_DET_ARBITER -- requirements
Module: seq_det_arbiter

Interface
REQ-001 Parameter: CNT_W, 8, width of match_cnt; saturating match counter.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0, req1  input  1 each  requester wants the shared detector for one frame; held high for the whole frame.
REQ-005 din0, din1  input  1 each  serial data bit from requester 0/1; one bit consumed per granted cycle.
REQ-006 last0, last1  input  1 each  marks the consumed bit as the final bit of the frame.
REQ-007 gnt0, gnt1  output  1 each  registered grant; the bit on din/last of the granted channel is consumed on every clock edge while grant is high.
REQ-008 det_111, det_101  output  1 each  registered one-cycle pulse: the consumed bit completed pattern 111 / 101.
REQ-009 done  output  1  one-cycle pulse: frame completed normally.
REQ-010 done_id  output  1  channel of the completed frame; valid when done=1.
REQ-011 match_cnt  output  CNT_W  running total of det_111 plus det_101 matches in the current or last frame.

Function
REQ-012 FSM states: IDLE, RUN, REPORT; at most one of gnt0/gnt1 high at any time; grants high only in RUN.
REQ-013 IDLE: if any req is high at an edge, go to RUN; the chosen grant is high from the next cycle; match_cnt is cleared to 0 and bit history is cleared at the same edge.
REQ-014 Arbitration is round-robin: a pointer names the priority channel; with both reqs high, the pointer channel wins; with one req high, that channel wins.
REQ-015 The pointer moves to the other channel after every frame that ends (done or abort); it is unchanged while IDLE.
REQ-016 RUN: on each edge, consume the granted din; shift it into a 2-bit history; track bits seen (0, 1, 2+).
REQ-017 Matching applies only with 2+ prior bits in the frame: history 11 with bit 1 gives det_111; history 10 with bit 1 gives det_101; detection overlaps (e.g. 1111 gives two 111s); history never carries across frames.
REQ-018 det pulses are high in the cycle after the consuming edge; match_cnt increments by 1 at that same edge, saturating at 2^CNT_W-1.
REQ-019 If the consumed bit has last=1: go to REPORT; in the next cycle grant=0, done=1, done_id=channel, and any det pulse for that last bit is also visible.
REQ-020 REPORT lasts exactly one cycle, then IDLE; match_cnt holds the frame total until the next frame starts.
REQ-021 Abort: if the granted req is low at an edge in RUN, no bit is consumed; go to IDLE, no done pulse; the pointer advances and match_cnt holds its value.
REQ-022 A request from the non-granted channel during RUN/REPORT waits; it is granted earliest 2 cycles after done.
REQ-023 last on the non-granted channel and din of the non-granted channel are ignored.

Reset
REQ-024 rst high at an edge, in any state including mid-frame: state=IDLE, pointer=0, history cleared, gnt0=gnt1=0, det_111=det_101=0, done=0, done_id=0, match_cnt=0 in the next cycle.
REQ-025 While rst is high, no bit is consumed and no grant is issued; rst has priority over all other inputs.

Verification
REQ-026 Reset, then req0 with the 20-bit frame 11100101001110010111 (last on bit 20) -> det_111 after bits 3, 13, 20; det_101 after bits 8, 18; done=1, done_id=0, match_cnt=5.
REQ-027 req0 and req1 both high from reset release -> ch0 granted first (pointer=0); after done, ch1 granted 2 cycles later; a third frame with both reqs high goes to ch0.
REQ-028 Frame of 300 ones on ch1, CNT_W=8 -> match_cnt saturates at 255, done_id=1.
REQ-029 Frame 1,1 on ch0 then req0 dropped before last -> no done, no det pulse, grant drops in the next cycle, a subsequent ch0 frame 1,1,1 gives one det_111 (no carry-over of history).
REQ-030 rst asserted on bit 5 of a granted frame -> all outputs 0 in the next cycle; after release, the first grant goes to ch0.
REQ-031 Frame 1,0,1,0,1 with last on bit 5 -> det_101 after bits 3 and 5; the last det_101 coincides with done; match_cnt=2.
